aes_cipher_ctrl: RTL and testbench
==================================

AES_CIPHER_CTRL -- requirements
Module: aes_cipher_ctrl

Interface
REQ-001 Parameter NR, default 10, number of cipher rounds (AES-128); legal range 1..15 (round index fits 4 bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  plaintext/key pair offered.
REQ-005 in_ready  output  1  block can accept a new pair this cycle.
REQ-006 key_in  input  [15:0][7:0]  cipher key; byte 15 = first FIPS-197 byte.
REQ-007 data_in  input  [15:0][7:0]  plaintext block, same byte order.
REQ-008 out_valid  output  1  ciphertext available on data_out.
REQ-009 out_ready  input  1  consumer takes ciphertext this cycle.
REQ-010 data_out  output  [15:0][7:0]  ciphertext.
REQ-011 rd_data  output  [15:0][7:0]  current state fed to the round datapath.
REQ-012 rd_key  output  [15:0][7:0]  current round key fed to the round datapath.
REQ-013 rd_rc  output  4  round index 1..NR for key expansion.
REQ-014 rd_last  output  1  high when rd_rc==NR; datapath omits MixColumns.
REQ-015 rd_out  input  [15:0][7:0]  combinational round result (state after AddRoundKey).
REQ-016 rd_keyout  input  [15:0][7:0]  combinational next round key.

Function
REQ-017 FSM states IDLE, RUN, DONE; reset enters IDLE.
REQ-018 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, else 0.
REQ-019 Accept = in_valid & in_ready; on accept: state_reg <= data_in ^ key_in, key_reg <= key_in, rc <= 1, go RUN.
REQ-020 In RUN each cycle: state_reg <= rd_out, key_reg <= rd_keyout; if rc==NR go DONE, else rc <= rc+1.
REQ-021 rd_data = state_reg, rd_key = key_reg, rd_rc = rc; all driven from registers, no combinational path from inputs.
REQ-022 Latency: out_valid rises exactly NR+1 edges after the accepting edge's preceding cycle, i.e. NR edges after the accept edge.
REQ-023 In DONE, out_valid=1 and data_out=state_reg, held stable until out_ready=1.
REQ-024 DONE with out_ready=1 and in_valid=0 -> IDLE next cycle; with in_valid=1 -> new accept, RUN next cycle (back-to-back, no bubble).
REQ-025 in_valid during RUN is ignored; key_in/data_in sampled only at accept.
REQ-026 out_valid is 0 in IDLE and RUN; data_out is 0 outside DONE.
REQ-027 rd_last = (state==RUN) & (rc==NR); 0 otherwise.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, rc=0, state_reg=0, key_reg=0, out_valid=0, rd_last=0.
REQ-029 in_ready SHALL be 0 while rst_n is low and 1 from the first cycle after release.
REQ-030 Reset mid-RUN or in DONE discards the block; no out_valid pulse follows.

Structure
REQ-031 Package aes_pkg SHALL hold typedef block_t ([15:0][7:0]), NR_AES128=10, and the FSM state enum.
REQ-032 No sub-module; the round datapath is external, wired via rd_* ports.

Verification
REQ-033 Bench wires a reference round datapath (SubBytes/ShiftRows/MixColumns-bypass-on-rd_last/KeyExpansion) to rd_* ports.
REQ-034 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_valid after 10 edges, data_out 69c4e0d86a7b0430d8cdb78070b4c55a; rd_rc sequence 1..10, rd_last only at 10.
REQ-035 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-036 Backpressure: out_ready=0 for 5 cycles after out_valid -> data_out stable, in_ready=0, then out_ready=1 -> IDLE.
REQ-037 Back-to-back: in_valid held with second vector while DONE and out_ready=1 -> second accept same cycle, second result 10 edges later, no bubble.
REQ-038 Reset asserted at rd_rc=5 -> outputs cleared immediately; after release out_valid stays 0 until a new accept.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES cipher round controller.
// block_t keeps FIPS-197 byte 0 in the most significant byte (index 15).
package aes_pkg;

  typedef logic [15:0][7:0] block_t;

  localparam int NR_AES128 = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/aes_cipher_ctrl.sv
// Iterative AES encryption controller: sequences NR rounds through an external
// combinational round datapath and hands the ciphertext out with valid/ready.
module aes_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  block_t     key_in,
  input  block_t     data_in,
  output logic       out_valid,
  input  logic       out_ready,
  output block_t     data_out,
  output block_t     rd_data,
  output block_t     rd_key,
  output logic [3:0] rd_rc,
  output logic       rd_last,
  input  block_t     rd_out,
  input  block_t     rd_keyout
);

  // NR must lie in 1..15 so the round index fits the 4-bit rd_rc port.
  localparam logic [3:0] NR_W = 4'(NR);

  state_e     r_fsm;
  state_e     w_fsm_nxt;
  block_t     r_data;
  block_t     r_key;
  logic [3:0] r_rc;
  logic       r_live;
  logic       w_accept;
  logic       w_ready;

  // Ready is held low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Handshake decode and next-state logic.
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_ready   = 1'b0;
    unique case (r_fsm)
      ST_IDLE: begin
        w_ready = r_live;
      end
      ST_RUN: begin
        w_ready = 1'b0;
      end
      ST_DONE: begin
        w_ready = r_live & out_ready;
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase
    w_accept = w_ready & in_valid;

    unique case (r_fsm)
      ST_IDLE: begin
        if (w_accept) begin
          w_fsm_nxt = ST_RUN;
        end else begin
          w_fsm_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_rc == NR_W) begin
          w_fsm_nxt = ST_DONE;
        end else begin
          w_fsm_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (w_accept) begin
          w_fsm_nxt = ST_RUN;
        end else if (out_ready) begin
          w_fsm_nxt = ST_IDLE;
        end else begin
          w_fsm_nxt = ST_DONE;
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase
  end

  // State, round key and round counter; an accept in DONE restarts directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= {16{8'h00}};
      r_key  <= {16{8'h00}};
      r_rc   <= 4'd0;
    end else if (w_accept) begin
      r_data <= data_in ^ key_in;
      r_key  <= key_in;
      r_rc   <= 4'd1;
    end else if (r_fsm == ST_RUN) begin
      r_data <= rd_out;
      r_key  <= rd_keyout;
      if (r_rc != NR_W) begin
        r_rc <= r_rc + 4'd1;
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = (r_fsm == ST_DONE);
  assign data_out  = (r_fsm == ST_DONE) ? r_data : {16{8'h00}};
  assign rd_data   = r_data;
  assign rd_key    = r_key;
  assign rd_rc     = r_rc;
  assign rd_last   = (r_fsm == ST_RUN) && (r_rc == NR_W);

endmodule

// File: tb/tb_aes_cipher_ctrl.sv
// Randomized scoreboard bench for aes_cipher_ctrl with a behavioural AES
// round datapath on the rd_* ports and a whole-block AES reference model.
module tb_aes_cipher_ctrl;
  import aes_pkg::*;

  localparam int NR = NR_AES128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] key_in = '0;
  logic [127:0] data_in = '0;
  logic         in_ready, out_valid, rd_last;
  logic [127:0] data_out, rd_data, rd_key, rd_out, rd_keyout;
  logic [3:0]   rd_rc;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [127:0] exp_q[$];
  int           acc_q[$];
  logic [7:0]   sbox[256];

  aes_cipher_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .key_in(key_in), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .rd_data(rd_data),
    .rd_key(rd_key), .rd_rc(rd_rc), .rd_last(rd_last), .rd_out(rd_out),
    .rd_keyout(rd_keyout)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- AES helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int k);
    return s[127-8*k -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox[gb(s, r + 4*((c + r) % 4))];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
      o[127-8*(4*c)   -: 8] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
      o[127-8*(4*c+3) -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input int i);
    logic [7:0] r = 8'h01;
    for (int j = 1; j < i; j++) r = xt(r);
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(int'(rc)), 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Whole-block reference: full key schedule up front, then NR rounds.
  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w[64];
    logic [31:0] t;
    logic [127:0] st;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i/4), 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    st = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= NR; r++) begin
      st = sub_shift(st);
      if (r != NR) st = mix(st);
      st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return st;
  endfunction

  assign rd_keyout = key_step(rd_key, rd_rc);
  assign rd_out    = (rd_last ? sub_shift(rd_data) : mix(sub_shift(rd_data))) ^ rd_keyout;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic         seen;
    logic [127:0] held;
    seen = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        acc_q.delete();
        seen = 1'b0;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 128'(out_valid), 128'd0);
        end else begin
          if (!seen) begin
            chk("latency", 128'(cyc - acc_q[0]), 128'(NR + 1));
            held = data_out;
            seen = 1'b1;
          end else begin
            chk("hold_stable", data_out, held);
          end
          if (out_ready) begin
            chk("data_out", data_out, exp_q[0]);
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            seen = 1'b0;
          end
        end
      end else begin
        chk("data_out_zero", data_out, 128'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] k, input logic [127:0] pt,
                      input logic [127:0] exp, input bit rbp);
    bit done = 1'b0;
    @(posedge clk); #1;
    key_in = k; data_in = pt; in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        acc_q.push_back(cyc);
        last_acc = cyc;
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (rbp) out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!done) chk("accept_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    logic [127:0] k, p;
    int a1, a2;
    bit hit;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b, r;
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gm(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      b = inv; r = inv;
      for (int j = 0; j < 4; j++) begin
        r = rotl1(r);
        b = b ^ r;
      end
      sbox[x] = b ^ 8'h63;
    end

    // Reset state
    #12;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_data_out", data_out, 128'd0);
    chk("rst_rd_rc", 128'(rd_rc), 128'd0);
    chk("rst_rd_last", 128'(rd_last), 128'd0);
    chk("rst_rd_data", rd_data, 128'd0);
    chk("rst_rd_key", rd_key, 128'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 128'(in_ready), 128'd1);

    // FIPS-197 C.1 with round index trace
    k = 128'h000102030405060708090a0b0c0d0e0f;
    p = 128'h00112233445566778899aabbccddeeff;
    chk("model_c1", aes_ref(k, p), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    send(k, p, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
    for (int i = 1; i <= NR; i++) begin
      chk("rd_rc_seq", 128'(rd_rc), 128'(i));
      chk("rd_last_seq", 128'(rd_last), 128'(i == NR));
      chk("run_out_valid", 128'(out_valid), 128'd0);
      @(posedge clk); #1;
    end
    chk("c1_done_valid", 128'(out_valid), 128'd1);
    drain();

    // FIPS-197 appendix B
    send(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
         128'h3925841d02dc09fbdc118597196a0b32, 1'b0);
    drain();

    // Backpressure
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    send(k, p, aes_ref(k, p), 1'b0);
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(posedge clk); #1;
      hit = out_valid;
    end
    chk("bp_valid_seen", 128'(hit), 128'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_valid", 128'(out_valid), 128'd0);
    chk("bp_idle_ready", 128'(in_ready), 128'd1);

    // Back-to-back: second vector waits on the inputs during the first run
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    send(k, p, aes_ref(k, p), 1'b0);
    a1 = last_acc;
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    send(k, p, aes_ref(k, p), 1'b0);
    a2 = last_acc;
    chk("b2b_no_bubble", 128'(a2 - a1), 128'(NR + 1));
    drain();

    // Reset in the middle of a run
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    send(k, p, aes_ref(k, p), 1'b0);
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      hit = (rd_rc == 4'd5);
      if (!hit) begin
        @(posedge clk); #1;
      end
    end
    chk("mid_rc5_seen", 128'(hit), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_last", 128'(rd_last), 128'd0);
    chk("mid_rst_rc", 128'(rd_rc), 128'd0);
    chk("mid_rst_data", rd_data, 128'd0);
    chk("mid_rst_ready", 128'(in_ready), 128'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2*NR; i++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 128'(out_valid), 128'd0);
    end
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    send(k, p, aes_ref(k, p), 1'b0);
    drain();

    // Random vectors with random consumer stalls
    for (int t = 0; t < 20; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      send(k, p, aes_ref(k, p), 1'b1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
